rca_config_programmer: RTL and testbench

- Write-side initiator for the RCA configuration register file.
- Accepts one complete RCA port-mapping request over a valid/ready handshake.
- Serialises the request into one register write per cycle on the config-regs write interface: rca select, port select, src/dest flag, 5-bit register address and write strobe.
- Sits between the decode/CSR path that issues RCA configuration instructions and the config register file.

---
 rtl/rca_cfg_pkg.sv | 54 +++++
 rtl/rca_config_programmer_if.sv | 55 +++++
 rtl/rca_cfg_next_slot.sv | 23 ++
 rtl/rca_config_programmer.sv | 173 +++++++++++++++++
 tb/tb_rca_config_programmer.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_cfg_pkg.sv
// Shared types and constants for the RCA configuration programmer.
// Optional readback verification is enabled with the RCA_CFG_VERIFY_EN macro.
package rca_cfg_pkg;

    localparam int NUM_RCAS        = 4;
    localparam int NUM_READ_PORTS  = 5;
    localparam int NUM_WRITE_PORTS = 5;
    localparam int ADDR_W          = 5;

    localparam int RCA_W      = $clog2(NUM_RCAS);
    localparam int SRC_SEL_W  = $clog2(NUM_READ_PORTS);
    localparam int DEST_SEL_W = $clog2(NUM_WRITE_PORTS);
    localparam int SRC_PTR_W  = $clog2(NUM_READ_PORTS + 1);
    localparam int DEST_PTR_W = $clog2(NUM_WRITE_PORTS + 1);

    typedef logic [RCA_W-1:0]      rca_id_t;
    typedef logic [SRC_SEL_W-1:0]  src_sel_t;
    typedef logic [DEST_SEL_W-1:0] dest_sel_t;

    typedef struct packed {
        rca_id_t                              id;
        logic [NUM_READ_PORTS*ADDR_W-1:0]     src_addrs;
        logic [NUM_READ_PORTS-1:0]            src_mask;
        logic [NUM_WRITE_PORTS*ADDR_W-1:0]    dest_addrs;
        logic [NUM_WRITE_PORTS-1:0]           dest_mask;
    } rca_cfg_req_t;

`ifdef RCA_CFG_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_SRC, ST_DEST, ST_VRD, ST_VCMP, ST_DONE
    } prog_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_SRC, ST_DEST, ST_DONE
    } prog_state_t;
`endif

    // Extract one 5-bit register address from a packed source slot vector
    function automatic logic [ADDR_W-1:0] src_slot(
        input logic [NUM_READ_PORTS*ADDR_W-1:0] addrs,
        input src_sel_t                         idx
    );
        return addrs[int'(idx)*ADDR_W +: ADDR_W];
    endfunction

    // Extract one 5-bit register address from a packed destination slot vector
    function automatic logic [ADDR_W-1:0] dest_slot(
        input logic [NUM_WRITE_PORTS*ADDR_W-1:0] addrs,
        input dest_sel_t                         idx
    );
        return addrs[int'(idx)*ADDR_W +: ADDR_W];
    endfunction

endpackage

// File: rtl/rca_config_programmer_if.sv
// Request handshake and config-register write bus of the RCA programmer.
// master = the programmer; slave = the requester plus the config register file.
// The readback signals exist only when RCA_CFG_VERIFY_EN is defined.
interface rca_config_programmer_if;
    import rca_cfg_pkg::*;

    logic                                 req_valid;
    logic                                 req_ready;
    rca_id_t                              req_rca_id;
    logic [NUM_READ_PORTS*ADDR_W-1:0]     req_src_addrs;
    logic [NUM_READ_PORTS-1:0]            req_src_mask;
    logic [NUM_WRITE_PORTS*ADDR_W-1:0]    req_dest_addrs;
    logic [NUM_WRITE_PORTS-1:0]           req_dest_mask;

    logic                                 cfg_we;
    rca_id_t                              cfg_rca_sel_w;
    src_sel_t                             cfg_src_port_sel;
    dest_sel_t                            cfg_dest_port_sel;
    logic                                 cfg_src_dest_port;
    logic [ADDR_W-1:0]                    cfg_reg_addr;
    logic                                 busy;
    logic                                 done;

`ifdef RCA_CFG_VERIFY_EN
    rca_id_t                              cfg_rca_sel_r;
    logic [NUM_READ_PORTS*ADDR_W-1:0]     cfg_src_reg_addrs;
    logic [NUM_WRITE_PORTS*ADDR_W-1:0]    cfg_dest_reg_addrs;
    logic                                 verify_err;
`endif

    modport master (
        input  req_valid, req_rca_id, req_src_addrs, req_src_mask,
               req_dest_addrs, req_dest_mask,
        output req_ready, cfg_we, cfg_rca_sel_w, cfg_src_port_sel,
               cfg_dest_port_sel, cfg_src_dest_port, cfg_reg_addr, busy, done
`ifdef RCA_CFG_VERIFY_EN
        ,
        output cfg_rca_sel_r, verify_err,
        input  cfg_src_reg_addrs, cfg_dest_reg_addrs
`endif
    );

    modport slave (
        output req_valid, req_rca_id, req_src_addrs, req_src_mask,
               req_dest_addrs, req_dest_mask,
        input  req_ready, cfg_we, cfg_rca_sel_w, cfg_src_port_sel,
               cfg_dest_port_sel, cfg_src_dest_port, cfg_reg_addr, busy, done
`ifdef RCA_CFG_VERIFY_EN
        ,
        input  cfg_rca_sel_r, verify_err,
        output cfg_src_reg_addrs, cfg_dest_reg_addrs
`endif
    );

endinterface

// File: rtl/rca_cfg_next_slot.sv
// Combinational finder: lowest set mask bit at or above a start index.
module rca_cfg_next_slot #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]           mask,
    input  logic [$clog2(WIDTH+1)-1:0] start,
    output logic [$clog2(WIDTH)-1:0]   index,
    output logic                       found
);

    // Scan from the top down so the lowest qualifying bit is the last one written
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                index = ($clog2(WIDTH))'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rca_config_programmer.sv
// RCA config programmer: accepts one port-mapping request and serialises it
// into one config-register write per cycle (source slots, then destination slots).
// Define RCA_CFG_VERIFY_EN to add a readback-and-compare pass before completion.
module rca_config_programmer
    import rca_cfg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    rca_config_programmer_if.master bus
);

    prog_state_t               state;
    rca_cfg_req_t              req_q;
    rca_cfg_req_t              incoming;
    rca_cfg_req_t              view;
    logic [SRC_PTR_W-1:0]      src_ptr;
    logic [SRC_PTR_W-1:0]      src_start;
    logic [DEST_PTR_W-1:0]     dest_ptr;
    logic [DEST_PTR_W-1:0]     dest_start;
    src_sel_t                  src_idx;
    dest_sel_t                 dest_idx;
    logic                      src_found;
    logic                      dest_found;
    logic                      accept;
    logic                      walking;

    assign incoming.id         = bus.req_rca_id;
    assign incoming.src_addrs  = bus.req_src_addrs;
    assign incoming.src_mask   = bus.req_src_mask;
    assign incoming.dest_addrs = bus.req_dest_addrs;
    assign incoming.dest_mask  = bus.req_dest_mask;

    assign accept  = bus.req_valid && bus.req_ready;
    assign walking = accept || (state == ST_SRC) || (state == ST_DEST);

    // On the accept cycle look straight at the incoming request so the first write registers immediately
    always_comb begin
        view       = req_q;
        src_start  = '0;
        dest_start = '0;
        if (state == ST_IDLE) begin
            view = incoming;
        end else begin
            src_start  = src_ptr;
            dest_start = dest_ptr;
        end
    end

    rca_cfg_next_slot #(.WIDTH(NUM_READ_PORTS)) u_src_slot (
        .mask  (view.src_mask),
        .start (src_start),
        .index (src_idx),
        .found (src_found)
    );

    rca_cfg_next_slot #(.WIDTH(NUM_WRITE_PORTS)) u_dest_slot (
        .mask  (view.dest_mask),
        .start (dest_start),
        .index (dest_idx),
        .found (dest_found)
    );

`ifdef RCA_CFG_VERIFY_EN
    logic verify_mismatch;

    // Compare each enabled slot of the readback against the latched request
    always_comb begin
        verify_mismatch = 1'b0;
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            if (req_q.src_mask[i] &&
                (bus.cfg_src_reg_addrs[i*ADDR_W +: ADDR_W] != req_q.src_addrs[i*ADDR_W +: ADDR_W]))
                verify_mismatch = 1'b1;
        end
        for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (req_q.dest_mask[j] &&
                (bus.cfg_dest_reg_addrs[j*ADDR_W +: ADDR_W] != req_q.dest_addrs[j*ADDR_W +: ADDR_W]))
                verify_mismatch = 1'b1;
        end
    end
`endif

    // Sequencer: latch the request, issue one write per cycle, then pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            req_q                 <= '0;
            src_ptr               <= '0;
            dest_ptr              <= '0;
            bus.req_ready         <= 1'b1;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.cfg_we            <= 1'b0;
            bus.cfg_rca_sel_w     <= '0;
            bus.cfg_src_port_sel  <= '0;
            bus.cfg_dest_port_sel <= '0;
            bus.cfg_src_dest_port <= 1'b0;
            bus.cfg_reg_addr      <= '0;
`ifdef RCA_CFG_VERIFY_EN
            bus.cfg_rca_sel_r     <= '0;
            bus.verify_err        <= 1'b0;
`endif
        end else begin
            bus.cfg_we <= 1'b0;
            bus.done   <= 1'b0;

            if (accept) begin
                req_q         <= incoming;
                bus.req_ready <= 1'b0;
                src_ptr       <= '0;
                dest_ptr      <= '0;
`ifdef RCA_CFG_VERIFY_EN
                bus.verify_err <= 1'b0;
`endif
            end

            if (walking) begin
                if ((state != ST_DEST) && src_found) begin
                    bus.cfg_we            <= 1'b1;
                    bus.cfg_src_dest_port <= 1'b0;
                    bus.cfg_src_port_sel  <= src_idx;
                    bus.cfg_reg_addr      <= src_slot(view.src_addrs, src_idx);
                    bus.cfg_rca_sel_w     <= view.id;
                    bus.busy              <= 1'b1;
                    src_ptr               <= SRC_PTR_W'(src_idx) + SRC_PTR_W'(1);
                    state                 <= ST_SRC;
                end else if (dest_found) begin
                    bus.cfg_we            <= 1'b1;
                    bus.cfg_src_dest_port <= 1'b1;
                    bus.cfg_dest_port_sel <= dest_idx;
                    bus.cfg_reg_addr      <= dest_slot(view.dest_addrs, dest_idx);
                    bus.cfg_rca_sel_w     <= view.id;
                    bus.busy              <= 1'b1;
                    dest_ptr              <= DEST_PTR_W'(dest_idx) + DEST_PTR_W'(1);
                    state                 <= ST_DEST;
                end else if (state == ST_IDLE) begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= ST_DONE;
                end else begin
`ifdef RCA_CFG_VERIFY_EN
                    bus.cfg_rca_sel_r <= req_q.id;
                    state             <= ST_VRD;
`else
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= ST_DONE;
`endif
                end
            end else begin
                case (state)
`ifdef RCA_CFG_VERIFY_EN
                    ST_VRD: begin
                        state <= ST_VCMP;
                    end
                    ST_VCMP: begin
                        bus.verify_err <= verify_mismatch;
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= ST_DONE;
                    end
`endif
                    ST_DONE: begin
                        bus.req_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rca_config_programmer.sv
// Self-checking bench for rca_config_programmer: a queue-based cycle model of
// the expected outputs, a per-cycle compare process, and directed tests with
// literal timing/address expectations. Covers RCA_CFG_VERIFY_EN when defined.
module tb_rca_config_programmer;
    import rca_cfg_pkg::*;

`ifdef RCA_CFG_VERIFY_EN
    localparam int VLAT = 2;
`else
    localparam int VLAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rca_config_programmer_if bus();

    rca_config_programmer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int we; int sd; int ssel; int dsel; int addr; int rca;
        int done; int busy; int ready; int err;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc_cyc = -100;
    bit   chk_en = 1'b0;
    bit   corrupt = 1'b0;
    exp_t plan[$];
    exp_t cur;
    int   held_sd, held_ssel, held_dsel, held_addr, held_rca, held_err;

    int   obs_we_cyc[$];
    int   obs_addr[$];
    int   obs_sd[$];
    int   obs_sel[$];
    int   obs_rca[$];
    int   obs_done_cyc[$];
    int   obs_done_err[$];
    int   obs_ready_cyc[$];
    int   prev_ready = 1;

    function automatic exp_t idleEntry();
        exp_t e;
        e = '{default: 0};
        e.ready = 1;
        return e;
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [24:0] packSeq(input int base);
        logic [24:0] v;
        for (int i = 0; i < 5; i++) v[i*5 +: 5] = 5'(base + i);
        return v;
    endfunction

    function automatic void clearObs();
        obs_we_cyc.delete(); obs_addr.delete(); obs_sd.delete(); obs_sel.delete();
        obs_rca.delete(); obs_done_cyc.delete(); obs_done_err.delete(); obs_ready_cyc.delete();
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: on accept, plan every expected output cycle of the request as a queue
    always @(posedge clk) begin
        bit acc;
        int n;
        exp_t e;
        cyc++;
        if (rst) begin
            plan.delete();
            cur = idleEntry();
            held_sd = 0; held_ssel = 0; held_dsel = 0; held_addr = 0; held_rca = 0; held_err = 0;
        end else begin
            acc = (cur.ready == 1) && (bus.req_valid == 1'b1);
            if (acc) begin
                last_acc_cyc = cyc - 1;
                n = 0;
                for (int i = 0; i < NUM_READ_PORTS; i++) begin
                    if (bus.req_src_mask[i]) begin
                        e = '{default: 0};
                        e.we = 1; e.sd = 0; e.ssel = i; e.busy = 1;
                        e.addr = int'(bus.req_src_addrs[i*5 +: 5]);
                        e.rca = int'(bus.req_rca_id);
                        plan.push_back(e); n++;
                    end
                end
                for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
                    if (bus.req_dest_mask[j]) begin
                        e = '{default: 0};
                        e.we = 1; e.sd = 1; e.dsel = j; e.busy = 1;
                        e.addr = int'(bus.req_dest_addrs[j*5 +: 5]);
                        e.rca = int'(bus.req_rca_id);
                        plan.push_back(e); n++;
                    end
                end
                if (n > 0) begin
                    for (int k = 0; k < VLAT; k++) begin
                        e = '{default: 0};
                        e.busy = 1;
                        plan.push_back(e);
                    end
                end
                e = '{default: 0};
                e.done = 1;
                e.err = (VLAT > 0 && n > 0 && corrupt && bus.req_src_mask[3]) ? 1 : 0;
                plan.push_back(e);
                held_err = 0;
            end
            if (plan.size() > 0) cur = plan.pop_front();
            else cur = idleEntry();
            if (cur.we == 1) begin
                held_sd = cur.sd; held_addr = cur.addr; held_rca = cur.rca;
                if (cur.sd == 1) held_dsel = cur.dsel;
                else held_ssel = cur.ssel;
            end
            if (cur.done == 1) held_err = cur.err;
        end
    end

`ifdef RCA_CFG_VERIFY_EN
    logic [4:0] rf_src  [NUM_RCAS][NUM_READ_PORTS];
    logic [4:0] rf_dest [NUM_RCAS][NUM_WRITE_PORTS];

    // Config register file stand-in with registered readback; slot 3 can be corrupted
    always @(posedge clk) begin
        logic [24:0] s;
        logic [24:0] d;
        if (bus.cfg_we) begin
            if (bus.cfg_src_dest_port) rf_dest[bus.cfg_rca_sel_w][bus.cfg_dest_port_sel] <= bus.cfg_reg_addr;
            else                       rf_src[bus.cfg_rca_sel_w][bus.cfg_src_port_sel]   <= bus.cfg_reg_addr;
        end
        for (int i = 0; i < 5; i++) begin
            s[i*5 +: 5] = rf_src[bus.cfg_rca_sel_r][i];
            d[i*5 +: 5] = rf_dest[bus.cfg_rca_sel_r][i];
        end
        if (corrupt) s[15 +: 5] = s[15 +: 5] ^ 5'd1;
        bus.cfg_src_reg_addrs  <= s;
        bus.cfg_dest_reg_addrs <= d;
    end
`endif

    // Compare every output against the model each cycle and log observations
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("req_ready", int'(bus.req_ready), cur.ready);
            checkOutput("busy", int'(bus.busy), cur.busy);
            checkOutput("done", int'(bus.done), cur.done);
            checkOutput("cfg_we", int'(bus.cfg_we), cur.we);
            checkOutput("cfg_src_dest_port", int'(bus.cfg_src_dest_port), held_sd);
            checkOutput("cfg_src_port_sel", int'(bus.cfg_src_port_sel), held_ssel);
            checkOutput("cfg_dest_port_sel", int'(bus.cfg_dest_port_sel), held_dsel);
            checkOutput("cfg_reg_addr", int'(bus.cfg_reg_addr), held_addr);
            checkOutput("cfg_rca_sel_w", int'(bus.cfg_rca_sel_w), held_rca);
`ifdef RCA_CFG_VERIFY_EN
            checkOutput("verify_err", int'(bus.verify_err), held_err);
`endif
            if (bus.cfg_we) begin
                obs_we_cyc.push_back(cyc);
                obs_addr.push_back(int'(bus.cfg_reg_addr));
                obs_sd.push_back(int'(bus.cfg_src_dest_port));
                obs_sel.push_back(bus.cfg_src_dest_port ? int'(bus.cfg_dest_port_sel) : int'(bus.cfg_src_port_sel));
                obs_rca.push_back(int'(bus.cfg_rca_sel_w));
            end
            if (bus.done) begin
                obs_done_cyc.push_back(cyc);
`ifdef RCA_CFG_VERIFY_EN
                obs_done_err.push_back(int'(bus.verify_err));
`else
                obs_done_err.push_back(0);
`endif
            end
            if (bus.req_ready && prev_ready == 0) obs_ready_cyc.push_back(cyc);
            prev_ready = int'(bus.req_ready);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) until the model says it was accepted
    task automatic applyStimulus(input int id, input logic [24:0] sa, input logic [4:0] sm,
                                 input logic [24:0] da, input logic [4:0] dm, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.req_valid      = 1'b1;
        bus.req_rca_id     = rca_id_t'(id);
        bus.req_src_addrs  = sa;
        bus.req_src_mask   = sm;
        bus.req_dest_addrs = da;
        bus.req_dest_mask  = dm;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            #1;
            if (last_acc_cyc == cyc - 1) begin
                got = 1'b1;
                acc = last_acc_cyc;
            end
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
    endtask

    // Withdraw the request and scramble the inputs, which must no longer matter
    task automatic dropReq();
        bus.req_valid      = 1'b0;
        bus.req_rca_id     = rca_id_t'($urandom);
        bus.req_src_addrs  = 25'($urandom);
        bus.req_src_mask   = 5'($urandom);
        bus.req_dest_addrs = 25'($urandom);
        bus.req_dest_mask  = 5'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int acc2;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rca_id = '0;
        bus.req_src_addrs = '0;
        bus.req_src_mask = '0;
        bus.req_dest_addrs = '0;
        bus.req_dest_mask = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] reset then idle");
        clearObs();
        waitCycles(10);
        checkOutput("idle_write_count", obs_we_cyc.size(), 0);
        checkOutput("idle_ready", int'(bus.req_ready), 1);

        $display("[TB] full request");
        clearObs();
        applyStimulus(2, packSeq(1), 5'b11111, packSeq(10), 5'b11111, acc);
        dropReq();
        waitCycles(16);
        checkOutput("full_write_count", obs_we_cyc.size(), 10);
        checkOutput("full_first_write_cyc", qat(obs_we_cyc, 0) - acc, 1);
        checkOutput("full_last_write_cyc", qat(obs_we_cyc, 9) - acc, 10);
        checkOutput("full_addr0", qat(obs_addr, 0), 1);
        checkOutput("full_addr4", qat(obs_addr, 4), 5);
        checkOutput("full_addr5", qat(obs_addr, 5), 10);
        checkOutput("full_addr9", qat(obs_addr, 9), 14);
        checkOutput("full_sd5", qat(obs_sd, 5), 1);
        checkOutput("full_rca", qat(obs_rca, 7), 2);
        checkOutput("full_done_cyc", qat(obs_done_cyc, 0) - acc, 11 + VLAT);
        checkOutput("full_ready_cyc", qat(obs_ready_cyc, 0) - acc, 12 + VLAT);

        $display("[TB] sparse masks");
        clearObs();
        applyStimulus(1, {5'd9, 5'd0, 5'd7, 5'd0, 5'd0}, 5'b10100,
                      {5'd0, 5'd0, 5'd0, 5'd0, 5'd21}, 5'b00001, acc);
        dropReq();
        waitCycles(10);
        checkOutput("sparse_write_count", obs_we_cyc.size(), 3);
        checkOutput("sparse_w0_cyc", qat(obs_we_cyc, 0) - acc, 1);
        checkOutput("sparse_w2_cyc", qat(obs_we_cyc, 2) - acc, 3);
        checkOutput("sparse_sel0", qat(obs_sel, 0), 2);
        checkOutput("sparse_sel1", qat(obs_sel, 1), 4);
        checkOutput("sparse_sel2", qat(obs_sel, 2), 0);
        checkOutput("sparse_addr1", qat(obs_addr, 1), 9);
        checkOutput("sparse_addr2", qat(obs_addr, 2), 21);
        checkOutput("sparse_sd2", qat(obs_sd, 2), 1);
        checkOutput("sparse_done_cyc", qat(obs_done_cyc, 0) - acc, 4 + VLAT);

        $display("[TB] empty request");
        clearObs();
        applyStimulus(3, packSeq(5), 5'b00000, packSeq(6), 5'b00000, acc);
        dropReq();
        waitCycles(6);
        checkOutput("empty_write_count", obs_we_cyc.size(), 0);
        checkOutput("empty_done_cyc", qat(obs_done_cyc, 0) - acc, 1);
        checkOutput("empty_ready_cyc", qat(obs_ready_cyc, 0) - acc, 2);

        $display("[TB] back-to-back with valid held");
        clearObs();
        applyStimulus(0, packSeq(3), 5'b00011, packSeq(0), 5'b00000, acc);
        applyStimulus(1, packSeq(0), 5'b00000, packSeq(20), 5'b00110, acc2);
        dropReq();
        waitCycles(12);
        checkOutput("b2b_spacing", acc2 - acc, 4 + VLAT);
        checkOutput("b2b_gap_after_done", qat(obs_we_cyc, 2) - qat(obs_done_cyc, 0), 2);
        checkOutput("b2b_addr2", qat(obs_addr, 2), 21);
        checkOutput("b2b_addr3", qat(obs_addr, 3), 22);
        checkOutput("b2b_rca2", qat(obs_rca, 2), 1);

        $display("[TB] reset mid-sequence");
        applyStimulus(2, packSeq(1), 5'b11111, packSeq(10), 5'b11111, acc);
        dropReq();
        waitCycles(3);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        clearObs();
        checkOutput("rst_ready_after_release", int'(bus.req_ready), 1);
        waitCycles(12);
        checkOutput("rst_no_more_writes", obs_we_cyc.size(), 0);
        checkOutput("rst_no_done", obs_done_cyc.size(), 0);

`ifdef RCA_CFG_VERIFY_EN
        $display("[TB] verify with corrupted readback");
        clearObs();
        corrupt = 1'b1;
        applyStimulus(2, packSeq(1), 5'b11111, packSeq(10), 5'b11111, acc);
        dropReq();
        waitCycles(18);
        checkOutput("verify_bad_err", qat(obs_done_err, 0), 1);
        corrupt = 1'b0;
        clearObs();
        applyStimulus(1, packSeq(4), 5'b01011, packSeq(12), 5'b10000, acc);
        dropReq();
        waitCycles(12);
        checkOutput("verify_good_err", qat(obs_done_err, 0), 0);
        checkOutput("verify_good_done_cyc", qat(obs_done_cyc, 0) - acc, 4 + 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
